demux4w_deser: RTL and testbench

- Downstream consumer of the 4-way single-bit demultiplexer.
- Takes the four demux outputs plus the select and a valid strobe that drove the demux.
- Assembles each channel's bit stream into WIDTH-bit words and holds one completed word per channel.
- Presents completed words on a single valid/ready output port, using round-robin arbitration across the four channels.

---
 rtl/demux4w_deser.sv | 154 +++++++++++++++
 tb/tb_demux4w_deser.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4w_deser.sv
// Per-channel deserializer behind a 4-way bit demux; one hold word per channel, round-robin output.
// Last bit at edge N -> out_valid after N+1; out_ready=0 holds the word, a full hold register drops new words (overflow).
module demux4w_deser #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       sel,
   input  logic             in1,
   input  logic             in2,
   input  logic             in3,
   input  logic             in4,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_chan,
   output logic [3:0]       overflow,
   input  logic             overflow_clr
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, PRESENT} state_t;

   logic [WIDTH-1:0] shreg_q [4];
   logic [WIDTH-1:0] shreg_d [4];
   logic [CW-1:0]    cnt_q   [4];
   logic [CW-1:0]    cnt_d   [4];
   logic [WIDTH-1:0] hold_q  [4];
   logic [WIDTH-1:0] hold_d  [4];
   logic [3:0]       hold_full_q, hold_full_d;
   logic [3:0]       overflow_q, overflow_d;
   logic [1:0]       rr_q, rr_d;
   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_chan_q, out_chan_d;

   logic [3:0]       in_bits;
   logic             cur_bit;
   logic             drain;
   logic [WIDTH-1:0] word;
   logic             grant_vld;
   logic [1:0]       grant;
   logic [1:0]       idx;

   assign in_bits = {in4, in3, in2, in1};
   assign cur_bit = in_bits[sel];
   assign drain   = (state_q == PRESENT) && out_valid_q && out_ready;

   // Walk from the farthest offset down so the channel nearest rr is the one kept.
   always_comb begin
      grant_vld = 1'b0;
      grant     = rr_q;
      idx       = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         idx = rr_q + 2'(i);
         if (hold_full_q[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   always_comb begin
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      overflow_d  = overflow_clr ? 4'b0000 : overflow_q;
      state_d     = state_q;
      rr_d        = rr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      word        = shreg_q[sel];
      word[cnt_q[sel]] = cur_bit;

      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               out_data_d  = hold_q[grant];
               out_chan_d  = grant;
               out_valid_d = 1'b1;
               state_d     = PRESENT;
            end
         end
         PRESENT: begin
            if (drain) begin
               hold_full_d[out_chan_q] = 1'b0;
               out_valid_d             = 1'b0;
               rr_d                    = out_chan_q + 2'd1;
               state_d                 = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Completion comes after the drain so a same-edge reload keeps hold_full set.
      if (in_valid) begin
         if (cnt_q[sel] == CNT_LAST) begin
            cnt_d[sel]   = '0;
            shreg_d[sel] = '0;
            if (!hold_full_q[sel] || (drain && (out_chan_q == sel))) begin
               hold_d[sel]      = word;
               hold_full_d[sel] = 1'b1;
            end else begin
               overflow_d[sel] = 1'b1;
            end
         end else begin
            shreg_d[sel] = word;
            cnt_d[sel]   = cnt_q[sel] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 4; c++) begin
            shreg_q[c] <= '0;
            cnt_q[c]   <= '0;
            hold_q[c]  <= '0;
         end
         hold_full_q <= 4'b0000;
         overflow_q  <= 4'b0000;
         rr_q        <= 2'd0;
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= 2'd0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            shreg_q[c] <= shreg_d[c];
            cnt_q[c]   <= cnt_d[c];
            hold_q[c]  <= hold_d[c];
         end
         hold_full_q <= hold_full_d;
         overflow_q  <= overflow_d;
         rr_q        <= rr_d;
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_demux4w_deser.sv
// Bench for demux4w_deser at WIDTH=4: table of single-channel words plus hand-written corner sequences.
module tb_demux4w_deser;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [1:0]   sel;
   logic         in1, in2, in3, in4;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   out_chan;
   logic [3:0]   overflow;
   logic         overflow_clr;

   demux4w_deser #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .sel          (sel),
      .in1          (in1),
      .in2          (in2),
      .in3          (in3),
      .in4          (in4),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_chan     (out_chan),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   // seq lists bits in arrival order, first bit in seq[3]; exp_data is the word expected out.
   typedef struct {
      logic [1:0] ch;
      logic [3:0] seq;
      logic [3:0] exp_data;
   } vec_t;

   typedef struct {
      logic [3:0] data;
      logic [1:0] chan;
   } beat_t;

   beat_t exp_q[$];
   beat_t obs_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    vcnt  = 0;
   vec_t  vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Sample on the falling edge, then return just after the next rising edge.
   task automatic tick();
      beat_t b;
      @(negedge clk);
      if (out_valid) vcnt++;
      if (out_valid && out_ready) begin
         b.data = out_data;
         b.chan = out_chan;
         obs_q.push_back(b);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic [1:0] ch, input logic b);
      logic [3:0] noise;
      noise = 4'($urandom);
      noise[ch] = b;
      in_valid = 1'b1;
      sel = ch;
      {in4, in3, in2, in1} = noise;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [1:0] ch, input logic [3:0] seq);
      for (int k = 3; k >= 0; k--) send_bit(ch, seq[k]);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         {in4, in3, in2, in1} = 4'($urandom);
         tick();
      end
   endtask

   task automatic expect_beat(input logic [3:0] data, input logic [1:0] chan);
      beat_t b;
      b.data = data;
      b.chan = chan;
      exp_q.push_back(b);
   endtask

   task automatic check_sb(input string name);
      beat_t e;
      beat_t o;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_missing: no word seen, expected data %0h chan %0d", name, e.data, e.chan);
         end else begin
            o = obs_q.pop_front();
            check({name, "_data"}, 32'(o.data), 32'(e.data));
            check({name, "_chan"}, 32'(o.chan), 32'(e.chan));
         end
      end
      check({name, "_extra"}, 32'(obs_q.size()), 32'd0);
      obs_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time budget");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{ch: 2'd1, seq: 4'b1011, exp_data: 4'b1101};
      vecs[1] = '{ch: 2'd0, seq: 4'b1111, exp_data: 4'hF};
      vecs[2] = '{ch: 2'd3, seq: 4'b0100, exp_data: 4'h2};
      vecs[3] = '{ch: 2'd2, seq: 4'b1000, exp_data: 4'h1};
      vecs[4] = '{ch: 2'd2, seq: 4'b0001, exp_data: 4'h8};
      vecs[5] = '{ch: 2'd3, seq: 4'b0110, exp_data: 4'h6};
      vecs[6] = '{ch: 2'd1, seq: 4'b1100, exp_data: 4'h3};
      vecs[7] = '{ch: 2'd0, seq: 4'b0101, exp_data: 4'hA};

      rst = 1'b1;
      in_valid = 1'b0;
      sel = 2'd0;
      {in4, in3, in2, in1} = 4'b0000;
      out_ready = 1'b0;
      overflow_clr = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_chan", 32'(out_chan), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      check("quiet_after_reset", 32'(obs_q.size()), 32'd0);

      // Single-channel words, one at a time, consumer always ready.
      out_ready = 1'b1;
      for (int v = 0; v < 8; v++) begin
         vcnt = 0;
         send_word(vecs[v].ch, vecs[v].seq);
         expect_beat(vecs[v].exp_data, vecs[v].ch);
         idle(6);
         check_sb("vec");
         check("vec_valid_cycles", 32'(vcnt), 32'd1);
         check("vec_overflow", 32'(overflow), 32'd0);
      end

      // ch0 and ch3 bits interleaved.
      begin
         logic [3:0] a;
         logic [3:0] c;
         a = 4'b1111;
         c = 4'b0100;
         for (int k = 3; k >= 0; k--) begin
            send_bit(2'd0, a[k]);
            send_bit(2'd3, c[k]);
         end
      end
      expect_beat(4'hF, 2'd0);
      expect_beat(4'h2, 2'd3);
      idle(8);
      check_sb("interleave");

      // All four channels fill while stalled, then drain in round-robin order.
      out_ready = 1'b0;
      send_word(2'd0, 4'b1000);
      send_word(2'd1, 4'b0100);
      send_word(2'd2, 4'b1100);
      send_word(2'd3, 4'b0010);
      idle(2);
      check("stall_no_accept", 32'(obs_q.size()), 32'd0);
      check("stall_valid_held", 32'(out_valid), 32'd1);
      check("stall_chan_held", 32'(out_chan), 32'd0);
      expect_beat(4'h1, 2'd0);
      expect_beat(4'h2, 2'd1);
      expect_beat(4'h3, 2'd2);
      expect_beat(4'h4, 2'd3);
      out_ready = 1'b1;
      idle(12);
      check_sb("rr_round");

      // After ch3 drains the pointer wraps to 0: pending ch0 beats pending ch2.
      out_ready = 1'b0;
      send_word(2'd3, 4'b1110);
      send_word(2'd2, 4'b1001);
      send_word(2'd0, 4'b1010);
      expect_beat(4'h7, 2'd3);
      expect_beat(4'h5, 2'd0);
      expect_beat(4'h9, 2'd2);
      out_ready = 1'b1;
      idle(12);
      check_sb("rr_wrap");

      // Overflow on ch2: second word dropped, first preserved.
      out_ready = 1'b0;
      send_word(2'd2, 4'b0101);
      send_word(2'd2, 4'b1010);
      idle(1);
      check("ovf_set", 32'(overflow), 32'h4);
      expect_beat(4'hA, 2'd2);
      out_ready = 1'b1;
      idle(6);
      check_sb("ovf_drain");
      check("ovf_sticky", 32'(overflow), 32'h4);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'h0);

      // Set and clear of the same overflow bit on one edge: set wins.
      out_ready = 1'b0;
      send_word(2'd1, 4'b1000);
      send_bit(2'd1, 1'b1);
      send_bit(2'd1, 1'b0);
      send_bit(2'd1, 1'b0);
      overflow_clr = 1'b1;
      send_bit(2'd1, 1'b0);
      overflow_clr = 1'b0;
      check("ovf_set_wins", 32'(overflow), 32'h2);
      expect_beat(4'h1, 2'd1);
      out_ready = 1'b1;
      idle(6);
      check_sb("ovf_set_wins_drain");
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;

      // ch1 completes on the same edge its presented word is drained.
      out_ready = 1'b0;
      send_word(2'd1, 4'b0110);
      expect_beat(4'h6, 2'd1);
      idle(2);
      send_bit(2'd1, 1'b1);
      send_bit(2'd1, 1'b1);
      send_bit(2'd1, 1'b0);
      out_ready = 1'b1;
      send_bit(2'd1, 1'b0);
      expect_beat(4'h3, 2'd1);
      idle(6);
      check_sb("same_edge");
      check("same_edge_overflow", 32'(overflow), 32'd0);

      // Reset mid-word and mid-handshake.
      out_ready = 1'b0;
      send_word(2'd3, 4'b1000);
      send_word(2'd3, 4'b1000);
      send_bit(2'd0, 1'b1);
      send_bit(2'd0, 1'b1);
      check("pre_rst_overflow", 32'(overflow), 32'h8);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_out_chan", 32'(out_chan), 32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      obs_q.delete();
      exp_q.delete();
      out_ready = 1'b1;
      idle(4);
      check("post_rst_quiet", 32'(obs_q.size()), 32'd0);
      send_word(2'd0, 4'b0001);
      expect_beat(4'h8, 2'd0);
      idle(6);
      check_sb("post_rst_word");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
